// File: rtl/hz_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
package hz_pkg;

    typedef enum logic [1:0] {
        HZ_ALU  = 2'd0,
        HZ_LOAD = 2'd1,
        HZ_MUL  = 2'd2,
        HZ_DIV  = 2'd3
    } hz_kind_t;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_t;

    localparam int HZ_LAT_MIN = 0;
    localparam int HZ_LAT_MAX = 15;

    // Width able to hold the larger latency; never narrower than one bit.
    function automatic int hz_cnt_width(input int lat_a, input int lat_b);
        int lat_max;
        lat_max = (lat_a > lat_b) ? lat_a : lat_b;
        return (lat_max < 1) ? 1 : $clog2(lat_max + 1);
    endfunction

endpackage

// File: rtl/hz_sb_entry.sv
// One scoreboard slot: bubble countdown plus divide-pending flag for a register.
module hz_sb_entry
    import hz_pkg::*;
#(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_load_en,
    input  logic          i_dset,
    input  logic          i_dclr,
    output logic          o_pending
);

    logic [CW-1:0] r_cnt;
    logic          r_dpend;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt   <= '0;
            r_dpend <= 1'b0;
        end else begin
            if (i_load_en)
                r_cnt <= i_load_val;
            else if (r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;

            // A new divide into this register outranks completion of the old one.
            if (i_dset)
                r_dpend <= 1'b1;
            else if (i_dclr)
                r_dpend <= 1'b0;
        end
    end

    assign o_pending = (r_cnt != '0) | r_dpend;

endmodule

// File: rtl/stall_scoreboard.sv
// Decode-stage hazard detector: per-register countdown scoreboard, divider
// occupancy FSM, and the one-cycle-delayed bubble request for execute.
module stall_scoreboard
    import hz_pkg::*;
#(
    parameter int NREG         = 16,
    parameter int RW           = $clog2(NREG),
    parameter int LOAD_LATENCY = 1,
    parameter int MUL_LATENCY  = 3,
    parameter int CW           = hz_cnt_width(LOAD_LATENCY, MUL_LATENCY)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          dec_valid,
    input  hz_kind_t      dec_kind,
    input  logic [RW-1:0] dec_src0,
    input  logic [RW-1:0] dec_src1,
    input  logic          dec_src0_use,
    input  logic          dec_src1_use,
    input  logic [RW-1:0] dec_dst,
    input  logic          dec_dst_we,
    input  logic          div_done,
    output logic          stall_pc,
    output logic          issue,
    output logic          stall_phase,
    output logic          div_busy
);

    if (LOAD_LATENCY < HZ_LAT_MIN || LOAD_LATENCY > HZ_LAT_MAX) begin : g_bad_load_lat
        $error("stall_scoreboard: LOAD_LATENCY out of range");
    end
    if (MUL_LATENCY < HZ_LAT_MIN || MUL_LATENCY > HZ_LAT_MAX) begin : g_bad_mul_lat
        $error("stall_scoreboard: MUL_LATENCY out of range");
    end

    div_state_t    r_div_state;
    logic [RW-1:0] r_div_dst;
    logic          r_div_we;
    logic          r_stall_phase;

    logic [NREG-1:0] w_pending;
    logic [CW-1:0]   w_load_val;
    logic            w_raw;
    logic            w_waw;
    logic            w_struct;
    logic            w_stall;
    logic            w_issue;
    logic            w_div_issue;
    logic            w_div_clr;

    always_comb begin
        w_load_val = '0;
        case (dec_kind)
            HZ_LOAD: w_load_val = CW'(LOAD_LATENCY);
            HZ_MUL:  w_load_val = CW'(MUL_LATENCY);
            default: w_load_val = '0;
        endcase
    end

    assign w_raw    = (dec_src0_use & w_pending[dec_src0]) |
                      (dec_src1_use & w_pending[dec_src1]);
    assign w_waw    = dec_dst_we & w_pending[dec_dst];
    // The divider frees up in the same cycle it reports completion.
    assign w_struct = (dec_kind == HZ_DIV) & (r_div_state == DIV_BUSY) & ~div_done;

    assign w_stall     = dec_valid & (w_raw | w_waw | w_struct);
    assign w_issue     = dec_valid & ~w_stall;
    assign w_div_issue = w_issue & (dec_kind == HZ_DIV);
    assign w_div_clr   = (r_div_state == DIV_BUSY) & div_done & r_div_we;

    for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
        logic w_dst_hit;
        logic w_src_hit;

        assign w_dst_hit = (dec_dst == RW'(gi));
        assign w_src_hit = (r_div_dst == RW'(gi));

        hz_sb_entry #(
            .CW(CW)
        ) u_entry (
            .clk        (clk),
            .rstn       (rstn),
            .i_load_val (w_load_val),
            .i_load_en  (w_issue & dec_dst_we & w_dst_hit),
            .i_dset     (w_div_issue & dec_dst_we & w_dst_hit),
            .i_dclr     (w_div_clr & w_src_hit),
            .o_pending  (w_pending[gi])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div_state <= DIV_IDLE;
            r_div_dst   <= '0;
            r_div_we    <= 1'b0;
        end else begin
            case (r_div_state)
                DIV_IDLE: begin
                    if (w_div_issue) begin
                        r_div_state <= DIV_BUSY;
                        r_div_dst   <= dec_dst;
                        r_div_we    <= dec_dst_we;
                    end
                end
                DIV_BUSY: begin
                    if (w_div_issue) begin
                        r_div_dst <= dec_dst;
                        r_div_we  <= dec_dst_we;
                    end else if (div_done) begin
                        r_div_state <= DIV_IDLE;
                    end
                end
                default: r_div_state <= DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_stall_phase <= 1'b0;
        else
            r_stall_phase <= w_stall;
    end

    assign stall_pc    = w_stall;
    assign issue       = w_issue;
    assign stall_phase = r_stall_phase;
    assign div_busy    = (r_div_state == DIV_BUSY);

endmodule

// File: tb/tb_stall_scoreboard.sv
// Directed scoreboard bench for stall_scoreboard with LOAD_LATENCY=2, MUL_LATENCY=3.
module tb_stall_scoreboard;
    import hz_pkg::*;

    logic       clk;
    logic       rstn;
    logic       dec_valid;
    hz_kind_t   dec_kind;
    logic [3:0] dec_src0;
    logic [3:0] dec_src1;
    logic       dec_src0_use;
    logic       dec_src1_use;
    logic [3:0] dec_dst;
    logic       dec_dst_we;
    logic       div_done;
    logic       stall_pc;
    logic       issue;
    logic       stall_phase;
    logic       div_busy;

    stall_scoreboard #(
        .NREG         (16),
        .LOAD_LATENCY (2),
        .MUL_LATENCY  (3)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .dec_valid    (dec_valid),
        .dec_kind     (dec_kind),
        .dec_src0     (dec_src0),
        .dec_src1     (dec_src1),
        .dec_src0_use (dec_src0_use),
        .dec_src1_use (dec_src1_use),
        .dec_dst      (dec_dst),
        .dec_dst_we   (dec_dst_we),
        .div_done     (div_done),
        .stall_pc     (stall_pc),
        .issue        (issue),
        .stall_phase  (stall_phase),
        .div_busy     (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string nm;
        bit    stall;
        bit    iss;
        bit    phase;
        bit    busy;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   prev_stall = 1'b0;

    task automatic check(input string nm, input string field, input logic act, input bit exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got=%b want=%b", nm, field, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs, compare against the queued expectation.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.nm, "stall_pc",    stall_pc,    e.stall);
            check(e.nm, "issue",       issue,       e.iss);
            check(e.nm, "stall_phase", stall_phase, e.phase);
            check(e.nm, "div_busy",    div_busy,    e.busy);
            $display("txn %-10s stall=%b issue=%b phase=%b busy=%b", e.nm, stall_pc, issue, stall_phase, div_busy);
        end
    end

    // One cycle of stimulus; stall_phase expectation is the previous cycle's expected stall.
    task automatic step(input bit rn, input bit v, input hz_kind_t k,
                        input logic [3:0] s0, input bit u0,
                        input logic [3:0] s1, input bit u1,
                        input logic [3:0] d, input bit we, input bit done,
                        input bit e_stall, input bit e_issue, input bit e_busy,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rstn         = rn;
        dec_valid    = v;
        dec_kind     = k;
        dec_src0     = s0;
        dec_src0_use = u0;
        dec_src1     = s1;
        dec_src1_use = u1;
        dec_dst      = d;
        dec_dst_we   = we;
        div_done     = done;
        e.nm    = nm;
        e.stall = e_stall;
        e.iss   = e_issue;
        e.phase = rn ? prev_stall : 1'b0;
        e.busy  = e_busy;
        prev_stall = e_stall;
        q.push_back(e);
    endtask

    task automatic idle(input bit done, input bit e_busy, input string nm);
        step(1, 0, HZ_ALU, 4'd0, 0, 4'd0, 0, 4'd0, 0, done, 0, 0, e_busy, nm);
    endtask

    initial begin
        rstn = 1'b0; dec_valid = 1'b0; dec_kind = HZ_ALU;
        dec_src0 = '0; dec_src1 = '0; dec_src0_use = 1'b0; dec_src1_use = 1'b0;
        dec_dst = '0; dec_dst_we = 1'b0; div_done = 1'b0;

        // Reset state
        step(0, 0, HZ_ALU,  4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, 0, "rst_idle");
        step(0, 1, HZ_LOAD, 4'd0, 0, 4'd0, 0, 4'd3, 1, 0, 0, 1, 0, "rst_valid");
        idle(0, 0, "idle");

        // Load-use: two bubbles, issue on the third cycle
        step(1, 1, HZ_LOAD, 4'd0, 0, 4'd0, 0, 4'd3, 1, 0, 0, 1, 0, "ld_r3");
        step(1, 1, HZ_ALU,  4'd3, 1, 4'd0, 0, 4'd8, 1, 0, 1, 0, 0, "ld_use1");
        step(1, 1, HZ_ALU,  4'd3, 1, 4'd0, 0, 4'd8, 1, 0, 1, 0, 0, "ld_use2");
        step(1, 1, HZ_ALU,  4'd3, 1, 4'd0, 0, 4'd8, 1, 0, 0, 1, 0, "ld_use_go");
        idle(0, 0, "idle");

        // Multiply: three bubbles; unrelated and back-to-back ALU issue freely
        step(1, 1, HZ_MUL,  4'd0, 0, 4'd0, 0, 4'd4, 1, 0, 0, 1, 0, "mul_r4");
        step(1, 1, HZ_ALU,  4'd4, 1, 4'd5, 1, 4'd9, 1, 0, 1, 0, 0, "mul_use1");
        step(1, 1, HZ_ALU,  4'd4, 1, 4'd5, 1, 4'd9, 1, 0, 1, 0, 0, "mul_use2");
        step(1, 1, HZ_ALU,  4'd4, 1, 4'd5, 1, 4'd9, 1, 0, 1, 0, 0, "mul_use3");
        step(1, 1, HZ_ALU,  4'd4, 1, 4'd5, 1, 4'd9, 1, 0, 0, 1, 0, "mul_use_go");
        step(1, 1, HZ_ALU,  4'd6, 1, 4'd0, 0, 4'd10, 1, 0, 0, 1, 0, "unrel_r6");
        step(1, 1, HZ_ALU,  4'd0, 0, 4'd0, 0, 4'd11, 1, 0, 0, 1, 0, "alu_a");
        step(1, 1, HZ_ALU,  4'd11, 1, 4'd0, 0, 4'd12, 1, 0, 0, 1, 0, "alu_b");

        // WAW behind a load
        step(1, 1, HZ_LOAD, 4'd0, 0, 4'd0, 0, 4'd2, 1, 0, 0, 1, 0, "ld_r2");
        step(1, 1, HZ_ALU,  4'd0, 0, 4'd0, 0, 4'd2, 1, 0, 1, 0, 0, "waw1");
        step(1, 1, HZ_ALU,  4'd0, 0, 4'd0, 0, 4'd2, 1, 0, 1, 0, 0, "waw2");
        step(1, 1, HZ_ALU,  4'd0, 0, 4'd0, 0, 4'd2, 1, 0, 0, 1, 0, "waw_go");
        idle(1, 0, "done_idle");

        // Divide: consumer waits for div_done, issues the cycle after
        step(1, 1, HZ_DIV,  4'd0, 0, 4'd0, 0, 4'd5, 1, 0, 0, 1, 0, "div_r5");
        for (int i = 0; i < 19; i++)
            step(1, 1, HZ_ALU, 4'd5, 1, 4'd0, 0, 4'd13, 1, 0, 1, 0, 1, "div_wait");
        step(1, 1, HZ_ALU,  4'd5, 1, 4'd0, 0, 4'd13, 1, 1, 1, 0, 1, "div_done");
        step(1, 1, HZ_ALU,  4'd5, 1, 4'd0, 0, 4'd13, 1, 0, 0, 1, 0, "div_use_go");

        // Back-to-back divides: second issues in the done cycle
        step(1, 1, HZ_DIV,  4'd0, 0, 4'd0, 0, 4'd5, 1, 0, 0, 1, 0, "div2_r5");
        step(1, 1, HZ_DIV,  4'd0, 0, 4'd0, 0, 4'd7, 1, 0, 1, 0, 1, "div_struct1");
        step(1, 1, HZ_DIV,  4'd0, 0, 4'd0, 0, 4'd7, 1, 0, 1, 0, 1, "div_struct2");
        step(1, 1, HZ_DIV,  4'd0, 0, 4'd0, 0, 4'd7, 1, 1, 0, 1, 1, "div_r7_go");
        step(1, 1, HZ_ALU,  4'd5, 1, 4'd0, 0, 4'd0, 0, 0, 0, 1, 1, "r5_free");
        step(1, 1, HZ_ALU,  4'd0, 0, 4'd7, 1, 4'd0, 0, 0, 1, 0, 1, "r7_wait");
        step(1, 1, HZ_ALU,  4'd0, 0, 4'd7, 1, 4'd0, 0, 1, 1, 0, 1, "r7_done");
        step(1, 1, HZ_ALU,  4'd0, 0, 4'd7, 1, 4'd0, 0, 0, 0, 1, 0, "r7_go");

        // Reset during a multiply stall drops hazards at once
        step(1, 1, HZ_MUL,  4'd0, 0, 4'd0, 0, 4'd4, 1, 0, 0, 1, 0, "mul2_r4");
        step(1, 1, HZ_ALU,  4'd4, 1, 4'd0, 0, 4'd14, 1, 0, 1, 0, 0, "mul2_use1");
        step(1, 1, HZ_ALU,  4'd4, 1, 4'd0, 0, 4'd14, 1, 0, 1, 0, 0, "mul2_use2");
        step(0, 1, HZ_ALU,  4'd4, 1, 4'd0, 0, 4'd14, 1, 0, 0, 1, 0, "rst_mid");
        step(1, 1, HZ_ALU,  4'd4, 1, 4'd0, 0, 4'd14, 1, 0, 0, 1, 0, "post_rst");
        idle(0, 0, "idle");

        @(negedge clk);
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stall_scoreboard.md
# stall_scoreboard

Scoreboard-based hazard and stall controller for the decode stage of the micro-instruction pipeline. It generalises load-use stalling to per-register countdown tracking with a distinct latency per instruction class: ALU, load, fixed-latency multiply and variable-latency divide. It asserts `stall_pc` to hold fetch/decode while a hazard exists. It emits `stall_phase` one cycle later to inject a bubble into execute. Forwarding selection is unchanged and stays outside this block.

## Interface
Parameters:
- `NREG`, 16: number of architectural registers tracked; `RW = $clog2(NREG)`.
- `LOAD_LATENCY`, 1: bubbles a consumer issued directly after a load must take; range 0..15.
- `MUL_LATENCY`, 3: bubbles for a multiply result; range 0..15.
- `CW`, `$clog2(max(LOAD_LATENCY,MUL_LATENCY)+1)`: counter width; derived, do not override.

Ports:
- `clk`  in  1  clock; all state rises on posedge.
- `rstn`  in  1  asynchronous active-low reset.
- `dec_valid`  in  1  decode holds a valid micro-instruction.
- `dec_kind`  in  `hz_kind_t` (2)  HZ_ALU / HZ_LOAD / HZ_MUL / HZ_DIV.
- `dec_src0`, `dec_src1`  in  RW  source register indices.
- `dec_src0_use`, `dec_src1_use`  in  1  the corresponding source is read.
- `dec_dst`  in  RW  destination index.
- `dec_dst_we`  in  1  the instruction writes `dec_dst`.
- `div_done`  in  1  single-cycle pulse from the divider: result written.
- `stall_pc`  out  1  combinational; hold PC and decode this cycle.
- `issue`  out  1  combinational; `dec_valid & ~stall_pc`.
- `stall_phase`  out  1  registered copy of `stall_pc`; bubble into execute.
- `div_busy`  out  1  divider FSM in BUSY.

## Operation
- Per register r:
  - `cnt[r]` (CW bits): remaining bubbles a consumer must take.
  - `dpend[r]`: awaiting a divide result.
- Each cycle, every nonzero `cnt[r]` decrements by 1.
- On `issue` with `dec_dst_we`, `cnt[dec_dst]` is loaded according to `dec_kind`:
  - LOAD: `LOAD_LATENCY`.
  - MUL: `MUL_LATENCY`.
  - ALU: 0.
  - DIV: 0, with `dpend[dec_dst]` set.
- The issue load overrides that register's decrement in the same cycle.
- A source is pending when it is used and its `cnt != 0` or its `dpend = 1`.
- `stall_pc` = `dec_valid & (RAW | WAW | STRUCT)`, where:
  - RAW: either used source is pending.
  - WAW: `dec_dst_we` and `dec_dst` is pending.
  - STRUCT: `dec_kind == HZ_DIV` and `div_busy` and not `div_done`.
- All registers are tracked, including index 0.
- Divider FSM, states IDLE and BUSY:
  - IDLE → BUSY on `issue & HZ_DIV`. The FSM latches `div_dst` and `div_we` (`dec_dst_we`).
  - BUSY → IDLE on `div_done`, which clears `dpend[div_dst]` at that edge if `div_we`.
  - `div_done` together with a new DIV issue in the same cycle: the FSM stays BUSY and latches the new `div_dst`.
  - If both divides target the same register: the set for the new DIV wins over the clear.
  - `div_done` while IDLE is ignored.
- `dpend` is cleared on the edge of `div_done`. A dependent consumer therefore issues in the cycle after `div_done`, not the same cycle.
- When `dec_valid = 0`: no state is updated except counter decrement and divider completion; `stall_pc = 0`.

## Timing
- Reset (async, `rstn` = 0), effective mid-operation:
  - All `cnt` = 0, all `dpend` = 0, FSM in IDLE.
  - `stall_pc` = 0 while `dec_valid` = 0; `issue` = `dec_valid`; `stall_phase` = 0; `div_busy` = 0.
  - In-flight hazards are discarded.
- Load issued in cycle t, consumer presented in t+1: stalls in t+1 … t+LOAD_LATENCY and issues in t+LOAD_LATENCY+1.
- `stall_phase` in cycle n equals `stall_pc` of cycle n-1.
- Latency 0 produces no stall; the back-to-back ALU chain issues every cycle.
- A counter cannot wrap: it loads only from a parameter ≤ 2^CW−1 and stops at 0.

## Structure
- Shared package `hz_pkg`:
  - `hz_kind_t` enum.
  - `div_state_t` enum {DIV_IDLE, DIV_BUSY}.
  - Latency-range check constants.
- Sub-module `hz_sb_entry`, one per register via generate: holds `cnt` and `dpend` and reports `pending`.
  - Inputs: load value, load enable, dpend set, dpend clear.
  - When dpend set and clear arrive together, set wins.
- The top level holds the hazard compare, the divider FSM and the `stall_phase` flop.

## Test plan
- LOAD_LATENCY = 2: load r3 at t, ALU reads r3 at t+1 → `stall_pc` = 1 at t+1 and t+2, `issue` at t+3; `stall_phase` = 1 at t+2 and t+3.
- MUL_LATENCY = 3: MUL r4; the next instruction reads r4 and r5 → 3 stall cycles. An unrelated instruction reading r6 issues with no stall.
- DIV r5; a consumer of r5 waits; `div_done` at t+20 → consumer issues at t+21.
- DIV r5 busy; second DIV r7 presented → stalls until the `div_done` cycle, issues that cycle; `div_busy` stays 1 and `dpend[r5]` clears.
- WAW: load r2, then ALU writing r2 the next cycle → stalls LOAD_LATENCY cycles.
- Assert `rstn` = 0 mid-MUL-stall → `stall_pc` and `stall_phase` fall immediately. After release, a consumer of r4 issues at once.
